// File: rtl/iq_interleaver_pkg.sv
// Shared types for the I/Q write-side interleaver: sample width default and FSM state encoding.
package iq_interleaver_pkg;

    localparam int unsigned IQ_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_Q = 2'd1,
        SEND_I = 2'd2
    } state_t;

endpackage

// File: rtl/iq_interleaver_if.sv
// Sample-in and SDRAM-write-out handshake bundle; slave is the interleaver's view, master the environment's.
interface iq_interleaver_if #(
    parameter int unsigned IQ_W = 16
);
    logic            iq_valid;
    logic            iq_ready;
    logic [IQ_W-1:0] i_in;
    logic [IQ_W-1:0] q_in;
    logic            wr_valid;
    logic            wr_ready;
    logic [IQ_W-1:0] wr_data;
    logic            wr_last;

    modport slave (
        input  iq_valid, i_in, q_in, wr_ready,
        output iq_ready, wr_valid, wr_data, wr_last
    );

    modport master (
        output iq_valid, i_in, q_in, wr_ready,
        input  iq_ready, wr_valid, wr_data, wr_last
    );
endinterface

// File: rtl/iq_interleaver_pair_fifo.sv
// DEPTH x W show-ahead FIFO of {Q,I} pairs with synchronous clear and async active-low reset.
module iq_pair_fifo #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/iq_interleaver.sv
// Buffers I/Q pairs and writes them to SDRAM as Q then I words with burst-end marking.
// Define IQ_TWOS_COMP_EN for two's-complement inputs (MSB flipped to offset-binary at FIFO write).
module iq_interleaver
    import iq_interleaver_pkg::*;
#(
    parameter int unsigned IQ_W        = IQ_W_DEF,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned BURST_PAIRS = 256
) (
    input  logic                     M100CLK,
    input  logic                     reset_n,
    input  logic                     flush,
    iq_interleaver_if.slave          bus,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fill_level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned BW = (BURST_PAIRS > 1) ? $clog2(BURST_PAIRS) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_PAIRS - 1);

    state_t            state_q, state_d;
    logic [IQ_W-1:0]   wr_data_q, wr_data_d;
    logic              wr_valid_q, wr_valid_d;
    logic              wr_last_q, wr_last_d;
    logic [IQ_W-1:0]   i_hold_q, i_hold_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic              overflow_q, overflow_d;

    logic              fifo_full, fifo_empty, push, pop;
    logic [2*IQ_W-1:0] fifo_wdata, fifo_rdata;
    logic [IQ_W-1:0]   w_i, w_q;
    logic [AW:0]       fifo_count;

`ifdef IQ_TWOS_COMP_EN
    localparam logic [IQ_W-1:0] MSB_MASK = {1'b1, {(IQ_W-1){1'b0}}};
    assign w_i = bus.i_in ^ MSB_MASK;
    assign w_q = bus.q_in ^ MSB_MASK;
`else
    assign w_i = bus.i_in;
    assign w_q = bus.q_in;
`endif

    assign fifo_wdata   = {w_q, w_i};
    assign bus.iq_ready = !fifo_full;
    assign push         = bus.iq_valid && !fifo_full && !flush;
    assign bus.wr_valid = wr_valid_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.wr_last  = wr_last_q;
    assign overflow     = overflow_q;
    assign fill_level   = fifo_count;

    iq_pair_fifo #(
        .W     (2*IQ_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk   (M100CLK),
        .rst_n (reset_n),
        .clr   (flush),
        .push  (push),
        .pop   (pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        wr_data_d  = wr_data_q;
        wr_valid_d = wr_valid_q;
        wr_last_d  = wr_last_q;
        i_hold_d   = i_hold_q;
        burst_d    = burst_q;
        pop        = 1'b0;
        overflow_d = overflow_q | (bus.iq_valid & fifo_full);
        if (flush) begin
            state_d    = IDLE;
            wr_data_d  = '0;
            wr_valid_d = 1'b0;
            wr_last_d  = 1'b0;
            i_hold_d   = '0;
            burst_d    = '0;
            overflow_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        wr_data_d  = fifo_rdata[2*IQ_W-1 -: IQ_W];
                        i_hold_d   = fifo_rdata[IQ_W-1:0];
                        wr_valid_d = 1'b1;
                        state_d    = SEND_Q;
                    end else begin
                        wr_valid_d = 1'b0;
                    end
                end
                SEND_Q: begin
                    if (bus.wr_ready) begin
                        wr_data_d = i_hold_q;
                        wr_last_d = (burst_q == BURST_LAST);
                        state_d   = SEND_I;
                    end
                end
                SEND_I: begin
                    if (bus.wr_ready) begin
                        burst_d   = (burst_q == BURST_LAST) ? '0 : burst_q + BW'(1);
                        wr_last_d = 1'b0;
                        // Chain straight into the next pair so the word stream has no bubble.
                        if (!fifo_empty) begin
                            pop       = 1'b1;
                            wr_data_d = fifo_rdata[2*IQ_W-1 -: IQ_W];
                            i_hold_d  = fifo_rdata[IQ_W-1:0];
                            state_d   = SEND_Q;
                        end else begin
                            wr_valid_d = 1'b0;
                            state_d    = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge M100CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wr_data_q  <= '0;
            wr_valid_q <= 1'b0;
            wr_last_q  <= 1'b0;
            i_hold_q   <= '0;
            burst_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_data_q  <= wr_data_d;
            wr_valid_q <= wr_valid_d;
            wr_last_q  <= wr_last_d;
            i_hold_q   <= i_hold_d;
            burst_q    <= burst_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_iq_interleaver.sv
// Directed self-checking bench for iq_interleaver (DEPTH=16, BURST_PAIRS=4).
module tb_iq_interleaver;
    localparam int unsigned IQ_W  = 16;
    localparam int unsigned DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       flush;
    logic       overflow;
    logic [4:0] fill_level;
    int         n_tests = 0;
    int         n_fail  = 0;

    iq_interleaver_if #(.IQ_W(IQ_W)) bus ();

    iq_interleaver #(
        .IQ_W        (IQ_W),
        .DEPTH       (DEPTH),
        .BURST_PAIRS (4)
    ) dut (
        .M100CLK    (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .bus        (bus.slave),
        .overflow   (overflow),
        .fill_level (fill_level)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        bus.iq_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        flush = 1'b0;
        bus.iq_valid = 1'b0;
        bus.i_in = '0;
        bus.q_in = '0;
        bus.wr_ready = 1'b0;
        repeat (3) tick();
        n_tests++;
        if ({bus.wr_valid, bus.wr_last, overflow, bus.iq_ready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_flags: got v/l/ovf/rdy=%b required 0001",
                     {bus.wr_valid, bus.wr_last, overflow, bus.iq_ready});
        end
        n_tests++;
        if (bus.wr_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_data: got %h required 0000", bus.wr_data);
        end
        n_tests++;
        if (fill_level !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_fill: got %0d required 0", fill_level);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        do_flush();
        bus.wr_ready = 1'b1;
        bus.iq_valid = 1'b1;
        bus.i_in = 16'h1111;
        bus.q_in = 16'h2222;
        tick();
        bus.iq_valid = 1'b0;
        n_tests++;
        if (fill_level !== 5'd1 || bus.wr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_e0: got fill=%0d valid=%b required fill=1 valid=0", fill_level, bus.wr_valid);
        end
        tick();
        n_tests++;
        if (bus.wr_valid !== 1'b1 || bus.wr_data !== 16'h2222) begin
            n_fail++;
            $display("FAIL single_q: got valid=%b data=%h required 1/2222", bus.wr_valid, bus.wr_data);
        end
        tick();
        n_tests++;
        if (bus.wr_valid !== 1'b1 || bus.wr_data !== 16'h1111 || bus.wr_last !== 1'b0) begin
            n_fail++;
            $display("FAIL single_i: got valid=%b data=%h last=%b required 1/1111/0",
                     bus.wr_valid, bus.wr_data, bus.wr_last);
        end
        tick();
        n_tests++;
        if (bus.wr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drop: got valid=%b required 0", bus.wr_valid);
        end
    endtask

    // Pushes npairs back to back with wr_ready=1 and checks a contiguous Q,I stream.
    task automatic test_stream(input string name, input int npairs, input int last_a, input int last_b);
        logic [15:0] got_d [64];
        logic        got_l [64];
        int nw = 0;
        int first = -1;
        int lastc = -1;
        logic [15:0] exp_d;
        logic        exp_l;
        do_flush();
        bus.wr_ready = 1'b1;
        for (int c = 0; c < 2 * npairs + 6; c++) begin
            if (c < npairs) begin
                bus.iq_valid = 1'b1;
                bus.i_in = 16'(16'h0A00 + c);
                bus.q_in = 16'(16'h0B00 + c);
                n_tests++;
                if (bus.iq_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s_iq_ready[%0d]: got %b required 1", name, c, bus.iq_ready);
                end
            end else begin
                bus.iq_valid = 1'b0;
            end
            tick();
            if (bus.wr_valid === 1'b1) begin
                if (nw < 64) begin
                    got_d[nw] = bus.wr_data;
                    got_l[nw] = bus.wr_last;
                end
                if (first < 0) first = c;
                lastc = c;
                nw++;
            end
        end
        n_tests++;
        if (nw != 2 * npairs || lastc - first != 2 * npairs - 1) begin
            n_fail++;
            $display("FAIL %s_count: got %0d words over %0d cycles required %0d contiguous",
                     name, nw, lastc - first + 1, 2 * npairs);
        end
        for (int w = 0; w < 2 * npairs && w < nw; w++) begin
            exp_d = (w % 2 == 0) ? 16'(16'h0B00 + w / 2) : 16'(16'h0A00 + w / 2);
            exp_l = (w == last_a) || (w == last_b);
            n_tests++;
            if (got_d[w] !== exp_d || got_l[w] !== exp_l) begin
                n_fail++;
                $display("FAIL %s_word[%0d]: got %h last=%b required %h last=%b",
                         name, w, got_d[w], got_l[w], exp_d, exp_l);
            end
        end
    endtask

    task automatic test_back_to_back();
        test_stream("b2b", 4, 7, -1);
    endtask

    task automatic test_burst_wrap();
        test_stream("burst", 9, 7, 15);
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_d;
        logic        exp_l;
        do_flush();
        bus.wr_ready = 1'b0;
        for (int k = 0; k < DEPTH + 2; k++) begin
            bus.iq_valid = 1'b1;
            bus.i_in = 16'(16'h1000 + k);
            bus.q_in = 16'(16'h2000 + k);
            n_tests++;
            if (bus.iq_ready !== ((k <= DEPTH) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL bp_iq_ready[%0d]: got %b required %b", k, bus.iq_ready, (k <= DEPTH));
            end
            tick();
        end
        bus.iq_valid = 1'b0;
        n_tests++;
        if (fill_level !== 5'd16 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_full: got fill=%0d ovf=%b required 16/1", fill_level, overflow);
        end
        repeat (2) tick();
        n_tests++;
        if (bus.wr_valid !== 1'b1 || bus.wr_data !== 16'h2000 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold: got valid=%b data=%h ovf=%b required 1/2000/1",
                     bus.wr_valid, bus.wr_data, overflow);
        end
        bus.wr_ready = 1'b1;
        for (int w = 0; w < 2 * (DEPTH + 1); w++) begin
            exp_d = (w % 2 == 0) ? 16'(16'h2000 + w / 2) : 16'(16'h1000 + w / 2);
            exp_l = (w % 2 == 1) && ((w / 2) % 4 == 3);
            n_tests++;
            if (bus.wr_valid !== 1'b1 || bus.wr_data !== exp_d || bus.wr_last !== exp_l) begin
                n_fail++;
                $display("FAIL bp_word[%0d]: got valid=%b %h last=%b required 1 %h last=%b",
                         w, bus.wr_valid, bus.wr_data, bus.wr_last, exp_d, exp_l);
            end
            tick();
        end
        n_tests++;
        if (bus.wr_valid !== 1'b0 || fill_level !== 5'd0) begin
            n_fail++;
            $display("FAIL bp_drain: got valid=%b fill=%0d required 0/0", bus.wr_valid, fill_level);
        end
    endtask

    task automatic test_flush();
        do_flush();
        bus.wr_ready = 1'b0;
        for (int k = 0; k < DEPTH + 2; k++) begin
            bus.iq_valid = 1'b1;
            bus.i_in = 16'(16'h3000 + k);
            bus.q_in = 16'(16'h4000 + k);
            tick();
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_tests++;
        if (fill_level !== 5'd0 || bus.wr_valid !== 1'b0 || bus.wr_data !== 16'h0000 ||
            overflow !== 1'b0 || bus.iq_ready !== 1'b1 || bus.wr_last !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_state: got fill=%0d v=%b d=%h ovf=%b rdy=%b l=%b required 0/0/0000/0/1/0",
                     fill_level, bus.wr_valid, bus.wr_data, overflow, bus.iq_ready, bus.wr_last);
        end
        bus.iq_valid = 1'b0;
        bus.wr_ready = 1'b1;
        repeat (2) tick();
        n_tests++;
        if (bus.wr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_no_push: got valid=%b required 0", bus.wr_valid);
        end
    endtask

    task automatic test_reset_mid();
        do_flush();
        bus.wr_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.iq_valid = 1'b1;
            bus.i_in = 16'(16'h00C0 + k);
            bus.q_in = 16'(16'h00D0 + k);
            tick();
        end
        bus.iq_valid = 1'b0;
        bus.wr_ready = 1'b1;
        tick();
        n_tests++;
        if (bus.wr_data !== 16'h00C0 || fill_level !== 5'd3) begin
            n_fail++;
            $display("FAIL rmid_pre: got data=%h fill=%0d required 00c0/3", bus.wr_data, fill_level);
        end
        #1 reset_n = 1'b0;
        #1;
        n_tests++;
        if (bus.wr_valid !== 1'b0 || bus.wr_data !== 16'h0000 || bus.wr_last !== 1'b0 ||
            overflow !== 1'b0 || fill_level !== 5'd0 || bus.iq_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_reset: got v=%b d=%h l=%b ovf=%b fill=%0d rdy=%b required 0/0000/0/0/0/1",
                     bus.wr_valid, bus.wr_data, bus.wr_last, overflow, fill_level, bus.iq_ready);
        end
        reset_n = 1'b1;
        tick();
        bus.iq_valid = 1'b1;
        bus.i_in = 16'h5A5A;
        bus.q_in = 16'hA5A5;
        tick();
        bus.iq_valid = 1'b0;
        tick();
        n_tests++;
        if (bus.wr_valid !== 1'b1 || bus.wr_data !== 16'hA5A5) begin
            n_fail++;
            $display("FAIL rmid_q: got valid=%b data=%h required 1/a5a5", bus.wr_valid, bus.wr_data);
        end
        tick();
        n_tests++;
        if (bus.wr_valid !== 1'b1 || bus.wr_data !== 16'h5A5A) begin
            n_fail++;
            $display("FAIL rmid_i: got valid=%b data=%h required 1/5a5a", bus.wr_valid, bus.wr_data);
        end
        tick();
        n_tests++;
        if (bus.wr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_end: got valid=%b required 0", bus.wr_valid);
        end
    endtask

    task automatic test_twos_comp();
        logic [15:0] exp_q, exp_i;
`ifdef IQ_TWOS_COMP_EN
        exp_q = 16'hFFFF;
        exp_i = 16'h0000;
`else
        exp_q = 16'h7FFF;
        exp_i = 16'h8000;
`endif
        do_flush();
        bus.wr_ready = 1'b1;
        bus.iq_valid = 1'b1;
        bus.i_in = 16'h8000;
        bus.q_in = 16'h7FFF;
        tick();
        bus.iq_valid = 1'b0;
        tick();
        n_tests++;
        if (bus.wr_valid !== 1'b1 || bus.wr_data !== exp_q) begin
            n_fail++;
            $display("FAIL tc_q: got valid=%b data=%h required 1/%h", bus.wr_valid, bus.wr_data, exp_q);
        end
        tick();
        n_tests++;
        if (bus.wr_valid !== 1'b1 || bus.wr_data !== exp_i) begin
            n_fail++;
            $display("FAIL tc_i: got valid=%b data=%h required 1/%h", bus.wr_valid, bus.wr_data, exp_i);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_burst_wrap();
        test_flush();
        test_reset_mid();
        test_twos_comp();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
